// File: rtl/prescaler_pkg.sv
// Shared constants and helpers for the prescaler bank.
package prescaler_pkg;

  localparam int unsigned N_CH_DEF  = 5;
  localparam int unsigned CNT_W_DEF = 32;
  localparam longint unsigned BOARD_HZ = 64'd50_000_000;

  // Width of a channel index; at least one bit even for a single channel.
  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Period in clk cycles for a wanted tick rate; zero rate yields an off channel.
  function automatic logic [31:0] period_for_hz(input longint unsigned clk_hz,
                                                input longint unsigned hz);
    return (hz == 0) ? 32'd0 : 32'(clk_hz / hz);
  endfunction

  // Reset divisors for the 50 MHz board, ch0 at the LSB: 1kHz,100Hz,10Hz,1Hz,25kHz.
  localparam logic [N_CH_DEF*CNT_W_DEF-1:0] DIV_INIT_DEF = {
    period_for_hz(BOARD_HZ, 64'd25_000),
    period_for_hz(BOARD_HZ, 64'd1),
    period_for_hz(BOARD_HZ, 64'd10),
    period_for_hz(BOARD_HZ, 64'd100),
    period_for_hz(BOARD_HZ, 64'd1_000)
  };

endpackage

// File: rtl/prescaler_chan.sv
// One prescaler channel: counter, active/shadow divisor and registered tick/sq.
module prescaler_chan
  import prescaler_pkg::*;
#(
  parameter int unsigned      CNT_W   = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DIV_RST = '0
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  output logic             tick,
  output logic             sq,
  output logic             pend
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             pend_q, pend_d;
  logic             tick_q, tick_d;
  logic             sq_q, sq_d;
  logic             apply_c;
  logic [CNT_W-1:0] eff_div_c;

  // Next-state: sync restart, off channel, normal counting; then divisor apply and write capture.
  always_comb begin
    cnt_d     = cnt_q;
    div_d     = div_q;
    half_d    = half_q;
    shadow_d  = shadow_q;
    pend_d    = pend_q;
    tick_d    = 1'b0;
    sq_d      = sq_q;
    apply_c   = 1'b0;
    eff_div_c = pend_q ? shadow_q : div_q;

    if (sync) begin
      cnt_d   = '0;
      apply_c = pend_q;
      sq_d    = (eff_div_c >= CNT_W'(2));
    end else if (div_q == '0) begin
      cnt_d   = '0;
      sq_d    = 1'b0;
      apply_c = pend_q;
    end else if (en) begin
      if (cnt_q == div_q - CNT_W'(1)) begin
        cnt_d   = '0;
        tick_d  = 1'b1;
        apply_c = pend_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      sq_d = (div_q == CNT_W'(1)) || (cnt_q < half_q);
    end

    if (apply_c) begin
      div_d  = shadow_q;
      half_d = shadow_q >> 1;
      pend_d = 1'b0;
    end

    // A write in the wrap cycle lands after the apply, so it waits for the next wrap.
    if (wr) begin
      shadow_d = wr_div;
      pend_d   = 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt_q    <= '0;
      div_q    <= DIV_RST;
      half_q   <= DIV_RST >> 1;
      shadow_q <= '0;
      pend_q   <= 1'b0;
      tick_q   <= 1'b0;
      sq_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      half_q   <= half_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      tick_q   <= tick_d;
      sq_q     <= sq_d;
    end
  end

  assign tick = tick_q;
  assign sq   = sq_q;
  assign pend = pend_q;

endmodule

// File: rtl/prescaler_bank.sv
// N-channel programmable clock-enable generator with runtime divisor reload.
module prescaler_bank
  import prescaler_pkg::*;
#(
  parameter int unsigned               N_CH     = N_CH_DEF,
  parameter int unsigned               CNT_W    = CNT_W_DEF,
  parameter logic [N_CH*CNT_W-1:0]     DIV_INIT = DIV_INIT_DEF
) (
  input  logic                       clk_in,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       sync,
  input  logic                       cfg_we,
  input  logic [ch_idx_w(N_CH)-1:0]  cfg_ch,
  input  logic [CNT_W-1:0]           cfg_div,
  output logic [N_CH-1:0]            tick,
  output logic [N_CH-1:0]            sq,
  output logic [N_CH-1:0]            cfg_pend
);

  logic [N_CH-1:0] wr_c;

  // Decode the config write into per-channel strobes; out-of-range indices hit nothing.
  always_comb begin
    wr_c = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      wr_c[i] = cfg_we && (32'(cfg_ch) == i);
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    prescaler_chan #(
      .CNT_W   (CNT_W),
      .DIV_RST (DIV_INIT[g*CNT_W +: CNT_W])
    ) u_chan (
      .clk_in (clk_in),
      .rst    (rst),
      .en     (en),
      .sync   (sync),
      .wr     (wr_c[g]),
      .wr_div (cfg_div),
      .tick   (tick[g]),
      .sq     (sq[g]),
      .pend   (cfg_pend[g])
    );
  end

endmodule
